// File: rtl/z16_dmem_ctrl.sv
// Z16 data memory controller: request/response handshake, wait states,
// byte/word access with sign-extended byte loads, error flagging.
module z16_dmem_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_we,
  input  logic                  i_byte,
  input  logic                  i_sext,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);

  localparam logic [3:0] WS_LD =
    4'(WAIT_STATES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_A =
    (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [3:0] cnt_q, cnt_d;

  logic                  we_q;
  logic                  byte_q;
  logic                  sext_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rerr_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  idle;
  logic                  accept;
  logic                  commit;

  logic [LSB-1:0]        in_lane;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic                  in_err;

  logic                  op_we;
  logic                  op_byte;
  logic                  op_sext;
  logic                  op_err;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic [LSB-1:0]        op_lane;
  logic [IDXW-1:0]       op_word;

  logic [DATA_WIDTH-1:0] mem_rd;
  logic [7:0]            sel_byte;
  logic [DATA_WIDTH-1:0] rd_d;

  assign idle   = (state_q == S_IDLE);
  assign accept = i_req_valid && idle;

  assign in_lane = i_addr[LSB-1:0];
  assign in_idx  = i_addr >> LSB;
  assign in_err  = (!i_byte && in_lane != '0)
                || ({1'b0, in_idx} >= DEPTH_A);

  // With zero wait states the commit edge is the
  // accept edge, so the live request is used.
  assign op_we    = idle ? i_we    : we_q;
  assign op_byte  = idle ? i_byte  : byte_q;
  assign op_sext  = idle ? i_sext  : sext_q;
  assign op_err   = idle ? in_err  : err_q;
  assign op_addr  = idle ? i_addr  : addr_q;
  assign op_wdata = idle ? i_wdata : wdata_q;

  assign op_lane = op_addr[LSB-1:0];
  assign op_word = IDXW'(op_addr >> LSB);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_rd   = mem[op_word];
    sel_byte = mem_rd[{op_lane, 3'b000} +: 8];
    rd_d     = '0;
    if (op_err || op_we) begin
      rd_d = '0;
    end else if (op_byte) begin
      rd_d = {{(DATA_WIDTH-8){op_sext & sel_byte[7]}},
              sel_byte};
    end else begin
      rd_d = mem_rd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= i_we;
        byte_q  <= i_byte;
        sext_q  <= i_sext;
        err_q   <= in_err;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
      end
      if (commit) begin
        rdata_q <= rd_d;
        rerr_q  <= op_err;
      end
    end
  end

  // RAM has no reset; an async reset forces IDLE,
  // so a pending store never reaches its commit edge.
  always_ff @(posedge i_clk) begin
    if (commit && !op_err && op_we) begin
      if (op_byte) begin
        mem[op_word][{op_lane, 3'b000} +: 8]
          <= op_wdata[7:0];
      end else begin
        mem[op_word] <= op_wdata;
      end
    end
  end

  assign o_req_ready = idle;
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rdata     = rdata_q;
  assign o_err       = rerr_q;

endmodule
